// File: rtl/clk_period_monitor.sv
`default_nettype none
// ============================================================================
// Module  : clk_period_monitor
// Brief   : Measures high/low phase and period of an asynchronous clock-like
//           input in system-clock cycles and flags fast/slow/stuck/overflow.
// Revision: 1.0
// ============================================================================
module clk_period_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_PERIOD  = 18,
    parameter int MAX_PERIOD  = 22,
    parameter int TIMEOUT     = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             meas_valid,
    output logic             too_fast,
    output logic             too_slow,
    output logic             stuck,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] c_cnt_max    = '1;
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_timeout    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   c_min_period = (CNT_W+1)'(MIN_PERIOD);
    localparam logic [CNT_W:0]   c_max_period = (CNT_W+1)'(MAX_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RISE = 2'd1,
        S_MEAS_HIGH = 2'd2,
        S_MEAS_LOW  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hi_tmp;
    logic [CNT_W-1:0]       r_idle;
    logic                   r_ovf;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;
    logic                   w_timeout;
    logic                   w_cnt_sat;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic [CNT_W:0]         w_period;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_s & ~r_prev;
    assign w_fall    = ~w_s & r_prev;
    assign w_edge    = w_rise | w_fall;
    assign w_timeout = (r_idle == c_timeout) & ~w_edge;
    assign w_cnt_sat = (r_cnt == c_cnt_max);
    assign w_cnt_inc = w_cnt_sat ? r_cnt : r_cnt + c_one;
    assign w_period  = {1'b0, r_hi_tmp} + {1'b0, r_cnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_prev <= w_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hi_tmp   <= '0;
            r_idle     <= '0;
            r_ovf      <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period     <= '0;
            meas_valid <= 1'b0;
            too_fast   <= 1'b0;
            too_slow   <= 1'b0;
            stuck      <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_idle  <= '0;
                r_ovf   <= 1'b0;
            end else begin
                // Idle count mirrors the phase count: k cycles after an edge it reads k.
                if (r_state != S_IDLE) begin
                    r_idle <= w_edge ? c_one : r_idle + c_one;
                    if (w_rise) begin
                        stuck <= 1'b0;
                    end
                end

                case (r_state)
                    S_IDLE: begin
                        r_state <= S_WAIT_RISE;
                        r_idle  <= '0;
                    end
                    S_WAIT_RISE: begin
                        if (w_rise) begin
                            r_cnt   <= c_one;
                            r_ovf   <= 1'b0;
                            r_state <= S_MEAS_HIGH;
                        end
                    end
                    S_MEAS_HIGH: begin
                        r_ovf <= r_ovf | w_cnt_sat;
                        if (w_fall) begin
                            r_hi_tmp <= r_cnt;
                            r_cnt    <= c_one;
                            r_state  <= S_MEAS_LOW;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_MEAS_LOW: begin
                        if (w_rise) begin
                            high_cnt   <= r_hi_tmp;
                            low_cnt    <= r_cnt;
                            period     <= w_period;
                            meas_valid <= 1'b1;
                            too_fast   <= (w_period < c_min_period);
                            too_slow   <= (w_period > c_max_period);
                            overflow   <= r_ovf | w_cnt_sat;
                            r_ovf      <= 1'b0;
                            r_cnt      <= c_one;
                            r_state    <= S_MEAS_HIGH;
                        end else begin
                            r_ovf <= r_ovf | w_cnt_sat;
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase

                // A timeout overrides the state decision above; edges already suppress it.
                if ((r_state != S_IDLE) && w_timeout) begin
                    stuck   <= 1'b1;
                    r_state <= S_WAIT_RISE;
                    r_cnt   <= '0;
                    r_idle  <= '0;
                    r_ovf   <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_period_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_period_monitor
// Brief   : Scoreboard bench for clk_period_monitor (default and 4-bit builds).
// Revision: 1.0
// ============================================================================
module tb_clk_period_monitor;

    localparam int A_TIMEOUT = 1000;

    typedef struct {
        int hi;
        int lo;
        int per;
        bit tf;
        bit ts;
        bit ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b, sig_a, sig_b;
    logic [15:0] high_a, low_a;
    logic [16:0] period_a;
    logic        valid_a, fast_a, slow_a, stuck_a, ovf_a;
    logic [3:0]  high_b, low_b;
    logic [4:0]  period_b;
    logic        valid_b, fast_b, slow_b, stuck_b, ovf_b;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   off    = 2;
    bit   rand_phase = 1'b0;
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    clk_period_monitor u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .sig_in(sig_a),
        .high_cnt(high_a), .low_cnt(low_a), .period(period_a),
        .meas_valid(valid_a), .too_fast(fast_a), .too_slow(slow_a),
        .stuck(stuck_a), .overflow(ovf_a)
    );

    clk_period_monitor #(.CNT_W(4), .TIMEOUT(15)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .sig_in(sig_b),
        .high_cnt(high_b), .low_cnt(low_b), .period(period_b),
        .meas_valid(valid_b), .too_fast(fast_b), .too_slow(slow_b),
        .stuck(stuck_b), .overflow(ovf_b)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int h, input int l, input bit ov);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.per = h + l;
        e.tf  = (e.per < 18);
        e.ts  = (e.per > 22);
        e.ov  = ov;
        return e;
    endfunction

    // Signal changes always land off-edge, so a phase held n cycles is sampled as n.
    task automatic drive(input bit b, input logic v, input int n);
        if (b) sig_b = v;
        else   sig_a = v;
        if (rand_phase) off = $urandom_range(1, 9);
        repeat (n) @(posedge clk);
        #(off);
    endtask

    task automatic period_(input bit b, input int h, input int l, input bit ov);
        if (b) qb.push_back(mk(h, l, ov));
        else   qa.push_back(mk(h, l, ov));
        drive(b, 1'b1, h);
        drive(b, 1'b0, l);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && valid_a === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_valid", 1, 0);
            end else begin
                e = qa.pop_front();
                chk("a_high_cnt", high_a, e.hi);
                chk("a_low_cnt", low_a, e.lo);
                chk("a_period", period_a, e.per);
                chk("a_too_fast", fast_a, e.tf);
                chk("a_too_slow", slow_a, e.ts);
                chk("a_overflow", ovf_a, e.ov);
                chk("a_stuck_at_valid", stuck_a, 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && valid_b === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_valid", 1, 0);
            end else begin
                e = qb.pop_front();
                chk("b_high_cnt", high_b, e.hi);
                chk("b_low_cnt", low_b, e.lo);
                chk("b_period", period_b, e.per);
                chk("b_too_fast", fast_b, e.tf);
                chk("b_too_slow", slow_b, e.ts);
                chk("b_overflow", ovf_b, e.ov);
                chk("b_stuck_at_valid", stuck_b, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        sig_a = 1'b0;
        sig_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_high", high_a, 0);
        chk("rst_a_low", low_a, 0);
        chk("rst_a_period", period_a, 0);
        chk("rst_a_flags", {valid_a, fast_a, slow_a, stuck_a, ovf_a}, 0);
        chk("rst_b_outputs", {high_b, low_b, period_b, valid_b, fast_b, slow_b, stuck_b, ovf_b}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #(off);

        // Nominal 10/10
        en_a = 1'b1;
        drive(0, 1'b0, 5);
        repeat (4) period_(0, 10, 10, 0);

        // Duty, range and boundary periods
        period_(0, 7, 13, 0);
        period_(0, 5, 8, 0);
        period_(0, 12, 12, 0);
        period_(0, 9, 9, 0);
        period_(0, 11, 11, 0);
        period_(0, 8, 9, 0);
        period_(0, 12, 11, 0);

        // Stuck high: the rise completes the 12/11 measurement, then nothing moves
        sig_a = 1'b1;
        repeat (A_TIMEOUT + 2) @(posedge clk);
        #1;
        chk("a_stuck_before_timeout", stuck_a, 0);
        @(posedge clk);
        #1;
        chk("a_stuck_at_timeout", stuck_a, 1);
        repeat (1200 - A_TIMEOUT - 3) @(posedge clk);
        #1;
        chk("a_stuck_held", stuck_a, 1);
        #1;
        drive(0, 1'b0, 10);
        sig_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("a_stuck_before_rise_seen", stuck_a, 1);
        @(posedge clk);
        #1;
        chk("a_stuck_cleared_on_rise", stuck_a, 0);
        repeat (7) @(posedge clk);
        #1;
        qa.push_back(mk(10, 10, 0));
        drive(0, 1'b0, 10);
        period_(0, 10, 10, 0);

        // Enable dropped mid low phase
        drive(0, 1'b1, 10);
        drive(0, 1'b0, 5);
        en_a = 1'b0;
        repeat (3) begin
            drive(0, 1'b1, 10);
            drive(0, 1'b0, 10);
        end
        chk("a_hold_high", high_a, 10);
        chk("a_hold_low", low_a, 10);
        chk("a_hold_period", period_a, 20);
        chk("a_hold_flags", {valid_a, fast_a, slow_a, stuck_a, ovf_a}, 0);
        en_a = 1'b1;
        drive(0, 1'b0, 5);
        period_(0, 10, 10, 0);
        period_(0, 10, 10, 0);

        // Asynchronous reset mid phase
        drive(0, 1'b1, 10);
        drive(0, 1'b0, 5);
        #4;
        rst_n = 1'b0;
        #1;
        chk("arst_a_high", high_a, 0);
        chk("arst_a_low", low_a, 0);
        chk("arst_a_period", period_a, 0);
        chk("arst_a_flags", {valid_a, fast_a, slow_a, stuck_a, ovf_a}, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #(off);
        drive(0, 1'b0, 5);
        period_(0, 10, 10, 0);
        period_(0, 12, 8, 0);

        // Random sub-cycle edge placement
        rand_phase = 1'b1;
        repeat (50) period_(0, 10, 10, 0);
        rand_phase = 1'b0;
        off = 2;
        drive(0, 1'b1, 10);
        drive(0, 1'b0, 10);

        // 4-bit build: timeout beats a 20-cycle high, then saturation cases
        en_b = 1'b1;
        drive(1, 1'b0, 5);
        drive(1, 1'b1, 20);
        chk("b_stuck_long_high", stuck_b, 1);
        drive(1, 1'b0, 5);
        period_(1, 15, 5, 1);
        period_(1, 5, 5, 0);
        period_(1, 3, 15, 1);
        period_(1, 10, 10, 0);
        drive(1, 1'b1, 5);
        drive(1, 1'b0, 5);

        repeat (10) @(posedge clk);
        #1;
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
